bus_arbiter_reg: RTL

Parametrised, registered successor to the datapath bus multiplexer. It selects one of NUM_SRC source registers onto a shared WIDTH-bit bus using one-hot out-enables with fixed lowest-index priority, and registers the result so the bus is a clean flop output. It also detects multi-driver conflicts and, when idle, either holds the last value or drives zero instead of floating. It sits between the register file/special registers and all bus consumers in the CPU datapath.

---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_prio_enc.sv | 26 ++
 rtl/bus_arbiter_reg.sv | 87 ++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared constants and helpers for the registered bus arbiter.
package bus_pkg;

  localparam int BUS_WIDTH   = 32;
  localparam int BUS_NUM_SRC = 4;

  localparam int HOLD_LAST  = 1;
  localparam int DRIVE_ZERO = 0;

  // Select width never drops below one bit, even for a two-source bus.
  function automatic int sel_w(input int num_src);
    return (num_src <= 2) ? 1 : $clog2(num_src);
  endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Fixed lowest-index-first priority encoder with multi-request detect.
module bus_prio_enc
  import bus_pkg::*;
#(
  parameter int NUM_SRC = BUS_NUM_SRC,
  parameter int SEL_W   = sel_w(BUS_NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [SEL_W-1:0]   index,
  output logic               multi
);

  assign any = |req;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - NUM_SRC'(1)));

  always_comb begin
    index = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (req[i-1]) index = SEL_W'(i - 1);
    end
  end

endmodule

// File: rtl/bus_arbiter_reg.sv
// Registered one-hot bus multiplexer with conflict flag, sticky and counter.
// Optional counter enabled by defining BUS_CONFLICT_CNT_EN.
module bus_arbiter_reg
  import bus_pkg::*;
#(
  parameter int WIDTH   = BUS_WIDTH,
  parameter int NUM_SRC = BUS_NUM_SRC,
  parameter int CNT_W   = 8,
  parameter int HOLD    = HOLD_LAST,
  localparam int SEL_W  = sel_w(NUM_SRC)
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_SRC*WIDTH-1:0] bus_in,
  input  logic [NUM_SRC-1:0]       src_out,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [SEL_W-1:0]         bus_src,
  output logic                     conflict,
  output logic                     conflict_sticky,
  output logic [CNT_W-1:0]         conflict_cnt
);

  logic             any;
  logic             multi;
  logic [SEL_W-1:0] index;
  logic [WIDTH-1:0] sel_data;

  bus_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_enc (
    .req   (src_out),
    .any   (any),
    .index (index),
    .multi (multi)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (index == SEL_W'(i)) sel_data = bus_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      bus_out         <= '0;
      bus_valid       <= 1'b0;
      bus_src         <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
    end else begin
      bus_valid <= any;
      conflict  <= multi;
      if (any) begin
        bus_out <= sel_data;
        bus_src <= index;
      end else if (HOLD == DRIVE_ZERO) begin
        bus_out <= '0;
      end
      // A conflict in the same cycle as err_clr survives the clear.
      if (err_clr) conflict_sticky <= multi;
      else if (multi) conflict_sticky <= 1'b1;
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= multi ? CNT_W'(1) : '0;
    end else if (multi && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule
